// File: rtl/axi_wr_pkg.sv
// axi_wr_pkg: shared encodings, FSM states and strobe helper for the write burst generator
package axi_wr_pkg;
  typedef enum logic [1:0] {BURST_FIXED = 2'd0, BURST_INCR = 2'd1, BURST_WRAP = 2'd2} burst_e;
  typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_e;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int unsigned BOUND_4K = 4096;
  function automatic logic [7:0] strb_f(input logic [2:0] lane, input logic [2:0] size);
    logic [3:0] nb;
    logic [2:0] base;
    nb = 4'd1 << size;
    base = lane & ~3'(nb - 4'd1);
    return (8'((9'd1 << nb) - 9'd1) << base) & (8'hFF << lane);
  endfunction
endpackage

// File: rtl/axi_beat_addr.sv
// axi_beat_addr: combinational byte address of beat idx_i within a FIXED/INCR/WRAP burst
module axi_beat_addr import axi_wr_pkg::*; #(
  parameter int AW = 32
) (
  input  logic [AW-1:0] start_i,
  input  logic [7:0]    len_i,
  input  logic [2:0]    size_i,
  input  logic [1:0]    burst_i,
  input  logic [7:0]    idx_i,
  output logic [AW-1:0] addr_o
);
  logic [AW-1:0] bytes, aligned, off, wmask, base;
  assign bytes = AW'(1) << size_i;
  assign aligned = start_i & ~(bytes - AW'(1));
  assign off = AW'(idx_i) << size_i;
  assign wmask = ((AW'(len_i) + AW'(1)) << size_i) - AW'(1);
  assign base = start_i & ~wmask;
  assign addr_o = burst_i == BURST_FIXED ? start_i :
                  burst_i == BURST_WRAP  ? (base | ((aligned + off) & wmask)) :
                  idx_i == 8'd0          ? start_i : aligned + off;
endmodule

// File: rtl/axi_wr_burst_gen.sv
// axi_wr_burst_gen: one-command-at-a-time AXI write burst source; AXI_WR_GEN_BRESP_CHK_EN enables err_sticky
module axi_wr_burst_gen import axi_wr_pkg::*; #(
  parameter int AW = 32,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_addr,
  input  logic [7:0]    cmd_len,
  input  logic [2:0]    cmd_size,
  input  logic [1:0]    cmd_burst,
  input  logic [DW-1:0] cmd_seed,
  output logic [AW-1:0] awaddr_in,
  output logic [7:0]    awlen_in,
  output logic [2:0]    awsize_in,
  output logic [1:0]    awburst_in,
  output logic          awvalid_in,
  input  logic          axi_awready,
  output logic [DW-1:0] wdata_in,
  output logic [7:0]    wstrb_in,
  output logic          wvalid_in,
  input  logic          axi_wready,
  output logic          bready_in,
  input  logic          axi_bvalid,
  input  logic [1:0]    axi_bresp,
  output logic          done,
  output logic [1:0]    done_resp,
  output logic          err_sticky
);
  state_e        state_q;
  logic          cmd_ready_q, awvalid_q, wvalid_q, bready_q, done_q;
  logic [AW-1:0] addr_q;
  logic [7:0]    len_q, beat_q;
  logic [2:0]    size_q;
  logic [1:0]    burst_q, done_resp_q;
  logic [DW-1:0] seed_q, wdata_q;
  logic [7:0]    wstrb_q;
  logic [AW-1:0] cmd_bytes_d, cmd_last_d, beat_addr_d;
  logic [7:0]    idx_d;
  logic          cross_d, wrap_ok_d, legal_d;

  assign cmd_bytes_d = AW'(1) << cmd_size;
  assign cmd_last_d = (cmd_addr & ~(cmd_bytes_d - AW'(1))) + ((AW'(cmd_len) + AW'(1)) << cmd_size) - AW'(1);
  assign cross_d = (cmd_addr ^ cmd_last_d) >= AW'(BOUND_4K);
  assign wrap_ok_d = cmd_len inside {8'd1, 8'd3, 8'd7, 8'd15};
  assign legal_d = cmd_size <= 3'd3 && cmd_burst != 2'd3 &&
                   (cmd_burst != BURST_WRAP || wrap_ok_d) && (cmd_burst != BURST_INCR || !cross_d);
  assign idx_d = state_q == S_W ? beat_q + 8'd1 : 8'd0;

  axi_beat_addr #(.AW(AW)) u_addr (
    .start_i(addr_q),
    .len_i  (len_q),
    .size_i (size_q),
    .burst_i(burst_q),
    .idx_i  (idx_d),
    .addr_o (beat_addr_d)
  );

  // command FSM with registered channel outputs; beat payload is loaded one handshake ahead
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q <= S_IDLE;
      cmd_ready_q <= 1'b1;
      awvalid_q <= 1'b0;
      wvalid_q <= 1'b0;
      bready_q <= 1'b0;
      done_q <= 1'b0;
      done_resp_q <= 2'b00;
      addr_q <= '0;
      len_q <= '0;
      size_q <= '0;
      burst_q <= '0;
      seed_q <= '0;
      beat_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (cmd_valid) begin
          if (legal_d) begin
            addr_q <= cmd_addr;
            len_q <= cmd_len;
            size_q <= cmd_size;
            burst_q <= cmd_burst;
            seed_q <= cmd_seed;
            cmd_ready_q <= 1'b0;
            awvalid_q <= 1'b1;
            state_q <= S_AW;
          end else begin
            done_q <= 1'b1;
            done_resp_q <= RESP_SLVERR;
          end
        end
        S_AW: if (axi_awready) begin
          awvalid_q <= 1'b0;
          wvalid_q <= 1'b1;
          beat_q <= 8'd0;
          wdata_q <= seed_q;
          wstrb_q <= strb_f(beat_addr_d[2:0], size_q);
          state_q <= S_W;
        end
        S_W: if (axi_wready) begin
          if (beat_q == len_q) begin
            wvalid_q <= 1'b0;
            bready_q <= 1'b1;
            state_q <= S_B;
          end else begin
            beat_q <= idx_d;
            wdata_q <= seed_q + DW'(idx_d);
            wstrb_q <= strb_f(beat_addr_d[2:0], size_q);
          end
        end
        S_B: if (axi_bvalid) begin
          bready_q <= 1'b0;
          done_q <= 1'b1;
          done_resp_q <= axi_bresp;
          cmd_ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end

`ifdef AXI_WR_GEN_BRESP_CHK_EN
  logic err_q;
  // remember any rejected command or non-OKAY response until reset
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) err_q <= 1'b0;
    else if ((state_q == S_IDLE && cmd_valid && !legal_d) ||
             (state_q == S_B && axi_bvalid && axi_bresp != RESP_OKAY)) err_q <= 1'b1;
  assign err_sticky = err_q;
`else
  assign err_sticky = 1'b0;
`endif

  assign cmd_ready = cmd_ready_q;
  assign awaddr_in = addr_q;
  assign awlen_in = len_q;
  assign awsize_in = size_q;
  assign awburst_in = burst_q;
  assign awvalid_in = awvalid_q;
  assign wdata_in = wdata_q;
  assign wstrb_in = wstrb_q;
  assign wvalid_in = wvalid_q;
  assign bready_in = bready_q;
  assign done = done_q;
  assign done_resp = done_resp_q;
endmodule
